soc_io_seg7_disp: RTL and testbench

//  Parametrised N-digit hex 7-segment display controller for the SOC IO block.

---
 rtl/soc_io_seg7_pkg.sv | 45 ++++
 rtl/soc_io_seg7_glyph.sv | 21 ++
 rtl/soc_io_seg7_disp.sv | 110 +++++++++++
 tb/tb_soc_io_seg7_disp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/soc_io_seg7_pkg.sv
// Shared constants, CTRL layout and hex glyph table for the SOC IO 7-segment display.
package soc_io_seg7_pkg;

    localparam logic [1:0] SEG7_ADDR_VALUE = 2'd0;
    localparam logic [1:0] SEG7_ADDR_CTRL  = 2'd1;
    localparam logic [1:0] SEG7_ADDR_BLINK = 2'd2;
    localparam logic [1:0] SEG7_ADDR_DP    = 2'd3;

    localparam int unsigned SEG7_CTRL_EN     = 0;
    localparam int unsigned SEG7_CTRL_LZS    = 1;
    localparam int unsigned SEG7_CTRL_BLK_EN = 2;

    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    typedef struct packed {
        logic blk_en;
        logic lzs;
        logic en;
    } seg7_ctrl_t;

    // Active-low glyph, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg7_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0011000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/soc_io_seg7_glyph.sv
// Per-digit combinational glyph: nibble/blank/dp to active-low segments and dp.
module soc_io_seg7_glyph
    import soc_io_seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dp_in,
    output logic [6:0] glyph_c,
    output logic       dp_c
);

    always_comb begin
        glyph_c = SEG7_BLANK;
        dp_c    = 1'b1;
        if (!blank) begin
            glyph_c = seg7_glyph(nibble);
            dp_c    = ~dp_in;
        end
    end

endmodule

// File: rtl/soc_io_seg7_disp.sv
// N-digit hex 7-segment controller: register bank, blink timer, LZS and registered outputs.
module soc_io_seg7_disp
    import soc_io_seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 8,
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [1:0]            wr_addr,
    input  logic [4*DIGITS-1:0]   wr_data,
    output logic [7*DIGITS-1:0]   seg,
    output logic [DIGITS-1:0]     dp
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned SEG_W  = 7 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(BLINK_DIV);

    logic [DATA_W-1:0] value;
    seg7_ctrl_t        ctrl;
    logic [DIGITS-1:0] blink_mask;
    logic [DIGITS-1:0] dp_mask;
    logic [CNT_W-1:0]  blink_cnt;
    logic              phase;

    logic [DIGITS-1:0] nz_from_c;
    logic [DIGITS-1:0] blank_c;
    logic [SEG_W-1:0]  glyph_c;
    logic [DIGITS-1:0] dp_c;

    // Register bank; ready rises on the first edge out of reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ready   <= 1'b0;
            value      <= '0;
            ctrl       <= '0;
            blink_mask <= '0;
            dp_mask    <= '0;
        end else begin
            wr_ready <= 1'b1;
            if (wr_valid && wr_ready) begin
                case (wr_addr)
                    SEG7_ADDR_VALUE: value <= wr_data;
                    SEG7_ADDR_CTRL: begin
                        ctrl.en     <= wr_data[SEG7_CTRL_EN];
                        ctrl.lzs    <= wr_data[SEG7_CTRL_LZS];
                        ctrl.blk_en <= wr_data[SEG7_CTRL_BLK_EN];
                    end
                    SEG7_ADDR_BLINK: blink_mask <= wr_data[DIGITS-1:0];
                    SEG7_ADDR_DP:    dp_mask    <= wr_data[DIGITS-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Free-running blink timer; independent of EN/BLK_EN and writes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    // nz_from_c[i]: some nibble at or above digit i is non-zero
    always_comb begin
        logic acc;
        acc       = 1'b0;
        nz_from_c = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            acc          = acc | (|value[4*i +: 4]);
            nz_from_c[i] = acc;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign blank_c[i] = !ctrl.en
                          || (ctrl.blk_en && phase && blink_mask[i])
                          || (ctrl.lzs && !nz_from_c[i] && (i != 0));

        soc_io_seg7_glyph u_glyph (
            .nibble  (value[4*i +: 4]),
            .blank   (blank_c[i]),
            .dp_in   (dp_mask[i]),
            .glyph_c (glyph_c[7*i +: 7]),
            .dp_c    (dp_c[i])
        );
    end

    // Output stage with board polarity applied
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg <= {SEG_W{ACTIVE_LOW}};
            dp  <= {DIGITS{ACTIVE_LOW}};
        end else begin
            seg <= ACTIVE_LOW ? glyph_c : ~glyph_c;
            dp  <= ACTIVE_LOW ? dp_c : ~dp_c;
        end
    end

endmodule

// File: tb/tb_soc_io_seg7_disp.sv
// Directed scoreboard bench for soc_io_seg7_disp (DIGITS=8, BLINK_DIV=4, ACTIVE_LOW=1).
module tb_soc_io_seg7_disp;

    localparam int unsigned DIGITS    = 8;
    localparam int unsigned BLINK_DIV = 4;

    localparam logic [6:0] GLYPH_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [1:0]  wr_addr = 2'd0;
    logic [31:0] wr_data = '0;
    logic [55:0] seg;
    logic [7:0]  dp;

    soc_io_seg7_disp #(
        .DIGITS     (DIGITS),
        .BLINK_DIV  (BLINK_DIV),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset release (stimulus-side time base)
    int unsigned cyc;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    logic [31:0] m_value = '0;
    logic [2:0]  m_ctrl  = '0;
    logic [7:0]  m_blink = '0;
    logic [7:0]  m_dp    = '0;

    logic [63:0] exp_q [$];
    string       tag_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic logic [63:0] model(input logic [31:0] v, input logic [2:0] c,
                                          input logic [7:0] bm, input logic [7:0] dm,
                                          input logic ph);
        logic [55:0] s;
        logic [7:0]  d;
        logic        blanked;
        for (int i = 0; i < 8; i++) begin
            if (!c[0])                                blanked = 1'b1;
            else if (c[2] && ph && bm[i])             blanked = 1'b1;
            else if (c[1] && i != 0 && (v >> (4*i)) == 32'd0) blanked = 1'b1;
            else                                      blanked = 1'b0;
            s[7*i +: 7] = blanked ? 7'b1111111 : GLYPH_TAB[v[4*i +: 4]];
            d[i]        = blanked ? 1'b1 : ~dm[i];
        end
        return {d, s};
    endfunction

    function automatic logic phase_after(input int unsigned n);
        return ((n / BLINK_DIV) % 2) == 1;
    endfunction

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        @(posedge clk);
        #1;
        case (addr)
            2'd0: m_value = data;
            2'd1: m_ctrl  = data[2:0];
            2'd2: m_blink = data[7:0];
            default: m_dp = data[7:0];
        endcase
    endtask

    // Push the expectation for the next output edge, then compare once it lands
    task automatic observe(input string tag);
        logic [63:0] e;
        string       t;
        @(negedge clk);
        wr_valid = 1'b0;
        exp_q.push_back(model(m_value, m_ctrl, m_blink, m_dp, phase_after(cyc)));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, {dp, seg}, e);
    endtask

    initial begin
        // 1. reset and release
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_seg", 64'(seg), 64'({56{1'b1}}));
        cmp("rst_dp", 64'(dp), 64'(8'hFF));
        cmp("rst_ready", 64'(wr_ready), 64'(1'b0));
        @(negedge clk);
        resetn = 1'b1;
        #1;
        cmp("ready_before_edge", 64'(wr_ready), 64'(1'b0));
        @(posedge clk);
        #1;
        cmp("ready_after_edge", 64'(wr_ready), 64'(1'b1));

        // 2. enable
        wr(2'd0, 32'h0123ABCF);
        wr(2'd1, 32'd1);
        observe("en_on");
        cmp("en_d0", 64'(seg[6:0]),   64'(7'b0001110));
        cmp("en_d1", 64'(seg[13:7]),  64'(7'b1000110));
        cmp("en_d4", 64'(seg[34:28]), 64'(7'b0110000));
        cmp("en_d5", 64'(seg[41:35]), 64'(7'b0100100));
        cmp("en_d7", 64'(seg[55:49]), 64'(7'b1000000));
        wr(2'd1, 32'd0);
        observe("en_off");
        cmp("en_off_seg", 64'(seg), 64'({56{1'b1}}));

        // 3. leading-zero suppression
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h00000F00);
        observe("lzs_f00");
        cmp("lzs_hi_blank", 64'(seg[55:21]), 64'({35{1'b1}}));
        cmp("lzs_d2", 64'(seg[20:14]), 64'(7'b0001110));
        cmp("lzs_d10", 64'(seg[13:0]), 64'({7'b1000000, 7'b1000000}));
        wr(2'd0, 32'd0);
        observe("lzs_zero");
        cmp("lzs_zero_seg", 64'(seg), 64'({49'h1_FFFF_FFFF_FFFF, 7'b1000000}));

        // 4. blink on digit 0
        wr(2'd1, 32'd5);
        wr(2'd2, 32'h01);
        wr(2'd0, 32'h11111111);
        for (int k = 0; k < 12; k++) observe("blink");

        // 5. decimal points
        wr(2'd1, 32'd1);
        wr(2'd3, 32'hA5);
        observe("dp_en");
        cmp("dp_en_val", 64'(dp), 64'(8'h5A));
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd0);
        observe("dp_lzs");
        cmp("dp_lzs_val", 64'(dp), 64'(8'hFE));

        // 6. mid-operation reset, back-to-back writes, over-wide DP data
        wr(2'd1, 32'd5);
        wr(2'd2, 32'hFF);
        wr(2'd0, 32'h12345678);
        for (int k = 0; k < 5; k++) observe("blink_all");
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        cmp("midrst_seg", 64'(seg), 64'({56{1'b1}}));
        cmp("midrst_dp", 64'(dp), 64'(8'hFF));
        cmp("midrst_ready", 64'(wr_ready), 64'(1'b0));
        m_value = '0; m_ctrl = '0; m_blink = '0; m_dp = '0;
        wr_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        observe("post_rst");
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd1);
        wr(2'd0, 32'd2);
        wr(2'd0, 32'd3);
        observe("b2b");
        cmp("b2b_d0", 64'(seg[6:0]), 64'(7'b0110000));
        wr(2'd3, 32'hDEADBE5A);
        observe("dp_wide");
        cmp("dp_wide_val", 64'(dp), 64'(8'hA5));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
